min_max_tracker: RTL and testbench
==================================

MIN_MAX_TRACKER -- requirements
Module: min_max_tracker

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: port clk (rising edge) and port rst_n (0 = reset).
REQ-002 Parameter N, default 8: operand width in bits; operands are two's-complement signed.
REQ-003 Parameter CW, default 8: width of the count and index fields.
REQ-004 Ports, one per line:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data/in_last valid
- in_ready  output  1  block accepts an element this cycle
- in_data  input  N  signed operand
- in_last  input  1  final element of the current burst
- out_valid  output  1  result available
- out_ready  input  1  consumer takes the result
- out_min  output  N  signed minimum of the burst
- out_max  output  N  signed maximum of the burst
- out_min_idx  output  CW  index of the first occurrence of the minimum
- out_max_idx  output  CW  index of the first occurrence of the maximum
- out_count  output  CW  number of elements in the burst

Function
REQ-005 An element is accepted in a cycle where in_valid=1 and in_ready=1; no other cycle changes internal state except reset.
REQ-006 States SHALL be IDLE (no element yet), ACCUM (at least one element held), and DONE (result presented).
REQ-007 in_ready SHALL be 1 in IDLE and ACCUM and 0 in DONE, and it SHALL be a registered or state-decoded signal that does not depend on in_valid.
REQ-008 IDLE plus accept: min=max=in_data, min_idx=max_idx=0, count=1; the next state is DONE if in_last=1, otherwise ACCUM.
REQ-009 ACCUM plus accept: the element index equals the count before the increment.
REQ-010 In ACCUM, if in_data < min (signed compare), then min=in_data and min_idx=index.
REQ-011 In ACCUM, if max < in_data (signed compare), then max=in_data and max_idx=index.
REQ-012 Ties SHALL keep the earlier index.
REQ-013 On each accepted element in ACCUM, count increments by 1.
REQ-014 count and the index SHALL saturate at 2^CW-1; once saturated, further elements still update min/max values, and index-driven updates use the saturated index.
REQ-015 ACCUM plus accept with in_last=1 SHALL go to DONE after that element's update.
REQ-016 ACCUM with no accept holds all state.
REQ-017 Result latency: out_valid=1 in the cycle after the in_last element is accepted.
REQ-018 In DONE, out_valid=1, and out_min, out_max, out_min_idx, out_max_idx and out_count SHALL be stable until the handshake completes.
REQ-019 DONE with out_ready=1: the result is consumed at that edge, and the block goes to IDLE with out_valid=0 and in_ready=1 in the next cycle; no same-cycle pass-through of a new element.
REQ-020 DONE with out_ready=0: the block holds indefinitely.
REQ-021 Output ports SHALL reflect the internal registers at all times; their values outside DONE are don't-care for the consumer but deterministic.
REQ-022 Signed comparison SHALL be correct across the full range, including the most negative value (-2^(N-1)) and the most positive value (2^(N-1)-1); no arithmetic overflow is permitted (use a signed compare, not unsigned subtraction without sign correction).

Reset
REQ-023 When rst_n=0, the state SHALL be IDLE immediately (asynchronous), independent of clk.
REQ-024 Reset values: out_valid=0, in_ready=1 (released state IDLE), out_min=0, out_max=0, out_min_idx=0, out_max_idx=0, out_count=0.
REQ-025 Reset asserted mid-burst (ACCUM) or in DONE SHALL discard the partial or pending result; the first element accepted after release starts a new burst.
REQ-026 Reset release SHALL be clean on the next clk edge with rst_n=1.

Verification
REQ-027 N=8 burst 5, -3, 7, -3, 0 (last on 0), out_ready=1 -> one out_valid pulse; min=-3, min_idx=1, max=7, max_idx=2, count=5.
REQ-028 Single-element burst -128 with in_last=1 -> out_valid next cycle; min=max=-128, both idx=0, count=1.
REQ-029 Burst 127, -128, 127, -128; hold out_ready=0 for 4 cycles -> in_ready=0 and outputs stable throughout (min=-128 idx1, max=127 idx0, count=4); then out_ready=1 -> IDLE next cycle.
REQ-030 Random in_valid gaps during a 10-element burst -> result identical to the gap-free run; no element is lost or duplicated.
REQ-031 rst_n pulsed low mid-burst after 3 elements, then burst 2, 1 -> result min=1 idx1, max=2 idx0, count=2.
REQ-032 CW=2 with a 6-element burst -> count=3 (saturated); a minimum arriving at element 5 reports min_idx=3.

Source files
------------

// File: rtl/min_max_tracker.sv
// ---------------------------------------------------------------------------
// min_max_tracker
//
// Tracks the signed minimum and maximum of a burst of operands, together with
// the index of the first occurrence of each and the element count. A burst is
// terminated by in_last; the result is then presented on a valid/ready output
// handshake and held until consumed. No new element is accepted while a
// result is pending.
//
// Parameters
//   N   operand width in bits (two's-complement signed)
//   CW  width of the count and index fields (both saturate at 2^CW-1)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     in_data/in_last valid
//   in_ready     block accepts an element this cycle (0 while a result is pending)
//   in_data      signed operand
//   in_last      final element of the current burst
//   out_valid    result available
//   out_ready    consumer takes the result
//   out_min      signed minimum of the burst
//   out_max      signed maximum of the burst
//   out_min_idx  index of the first occurrence of the minimum
//   out_max_idx  index of the first occurrence of the maximum
//   out_count    number of elements in the burst (saturating)
// ---------------------------------------------------------------------------
module min_max_tracker #(
    parameter int N  = 8,
    parameter int CW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [N-1:0]  in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [N-1:0]  out_min,
    output logic signed [N-1:0]  out_max,
    output logic [CW-1:0]        out_min_idx,
    output logic [CW-1:0]        out_max_idx,
    output logic [CW-1:0]        out_count
);

    typedef enum logic [1:0] {
        IDLE,   // no element of the current burst held yet
        ACCUM,  // at least one element held, burst still open
        DONE    // result presented, waiting for out_ready
    } state_t;

    localparam logic [CW-1:0] COUNT_MAX = '1;

    state_t               state;
    logic signed [N-1:0]  min_r;
    logic signed [N-1:0]  max_r;
    logic [CW-1:0]        min_idx_r;
    logic [CW-1:0]        max_idx_r;
    logic [CW-1:0]        count_r;

    logic                 accept;
    logic [CW-1:0]        elem_idx;
    logic [CW-1:0]        count_next;

    // in_ready is decoded from state only, so it never combinationally
    // depends on in_valid.
    assign in_ready = (state != DONE);
    assign out_valid = (state == DONE);
    assign accept = in_valid && in_ready;

    // The element index is the count before the increment. Because count_r
    // itself saturates, the index saturates with it for free.
    assign elem_idx = count_r;
    assign count_next = (count_r == COUNT_MAX) ? count_r : count_r + 1'b1;

    // NOTE: every register here, including the result fields, is reset so the
    // outputs are deterministic after reset; non-blocking (<=) assignments
    // keep all updates in this block reading the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            min_r     <= '0;
            max_r     <= '0;
            min_idx_r <= '0;
            max_idx_r <= '0;
            count_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        min_r     <= in_data;
                        max_r     <= in_data;
                        min_idx_r <= '0;
                        max_idx_r <= '0;
                        count_r   <= CW'(1);
                        state     <= in_last ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        // Strict compares: a tie keeps the earlier index.
                        if (in_data < min_r) begin
                            min_r     <= in_data;
                            min_idx_r <= elem_idx;
                        end
                        if (max_r < in_data) begin
                            max_r     <= in_data;
                            max_idx_r <= elem_idx;
                        end
                        count_r <= count_next;
                        if (in_last) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // The result fields stay untouched here, so they are
                    // stable until the consumer takes them.
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_min     = min_r;
    assign out_max     = max_r;
    assign out_min_idx = min_idx_r;
    assign out_max_idx = max_idx_r;
    assign out_count   = count_r;

endmodule

// File: tb/tb_min_max_tracker.sv
// ---------------------------------------------------------------------------
// tb_min_max_tracker
//
// Self-checking bench for min_max_tracker. A table of bursts with
// hand-computed results is applied in a loop; hand-written sequences cover
// output back-pressure, input gaps, reset mid-burst and count saturation
// (a second instance with CW=2 shares the input stimulus).
// ---------------------------------------------------------------------------
module tb_min_max_tracker;

    localparam int N = 8;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic signed [N-1:0] in_data;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic signed [N-1:0] out_min;
    logic signed [N-1:0] out_max;
    logic [7:0]          out_min_idx;
    logic [7:0]          out_max_idx;
    logic [7:0]          out_count;

    // Narrow-count instance for the saturation case.
    logic                s_in_ready;
    logic                s_out_valid;
    logic signed [N-1:0] s_out_min;
    logic signed [N-1:0] s_out_max;
    logic [1:0]          s_out_min_idx;
    logic [1:0]          s_out_max_idx;
    logic [1:0]          s_out_count;

    min_max_tracker #(.N(N), .CW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_min    (out_min),
        .out_max    (out_max),
        .out_min_idx(out_min_idx),
        .out_max_idx(out_max_idx),
        .out_count  (out_count)
    );

    min_max_tracker #(.N(N), .CW(2)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (s_in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (s_out_valid),
        .out_ready  (out_ready),
        .out_min    (s_out_min),
        .out_max    (s_out_max),
        .out_min_idx(s_out_min_idx),
        .out_max_idx(s_out_max_idx),
        .out_count  (s_out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    len;
        int    data [10];
        int    exp_min;
        int    exp_min_idx;
        int    exp_max;
        int    exp_max_idx;
        int    exp_count;
    } burst_t;

    localparam int NUM_VEC = 6;
    burst_t vec [NUM_VEC];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Present one element and wait for the edge that accepts it. Inputs
    // change #1 after the rising edge; outputs are read at that same point.
    task automatic send(input int d, input logic last);
        in_valid = 1'b1;
        in_data  = N'(d);
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h5A;
    endtask

    // Wait (bounded) for the result, compare it, then consume it and confirm
    // the block is back in IDLE one cycle later.
    task automatic expect_result(input string name, input int emin, input int emin_idx,
                                 input int emax, input int emax_idx, input int ecount);
        for (int i = 0; i < 20 && !out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        check({name, " out_valid"}, int'(out_valid), 1);
        check({name, " min"}, int'(out_min), emin);
        check({name, " min_idx"}, int'(out_min_idx), emin_idx);
        check({name, " max"}, int'(out_max), emax);
        check({name, " max_idx"}, int'(out_max_idx), emax_idx);
        check({name, " count"}, int'(out_count), ecount);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, " idle out_valid"}, int'(out_valid), 0);
        check({name, " idle in_ready"}, int'(in_ready), 1);
    endtask

    // Gap-free burst from the table; latency is checked right after in_last.
    task automatic run_burst(input burst_t b);
        for (int i = 0; i < b.len; i++) begin
            check({b.name, " in_ready"}, int'(in_ready), 1);
            send(b.data[i], (i == b.len - 1));
        end
        check({b.name, " latency"}, int'(out_valid), 1);
        expect_result(b.name, b.exp_min, b.exp_min_idx, b.exp_max, b.exp_max_idx, b.exp_count);
    endtask

    initial begin
        vec[0] = '{name:"mixed", len:5, data:'{5, -3, 7, -3, 0, 0, 0, 0, 0, 0},
                   exp_min:-3, exp_min_idx:1, exp_max:7, exp_max_idx:2, exp_count:5};
        vec[1] = '{name:"single", len:1, data:'{-128, 0, 0, 0, 0, 0, 0, 0, 0, 0},
                   exp_min:-128, exp_min_idx:0, exp_max:-128, exp_max_idx:0, exp_count:1};
        vec[2] = '{name:"ties", len:3, data:'{4, 4, 4, 0, 0, 0, 0, 0, 0, 0},
                   exp_min:4, exp_min_idx:0, exp_max:4, exp_max_idx:0, exp_count:3};
        vec[3] = '{name:"descend", len:4, data:'{127, 0, -1, -128, 0, 0, 0, 0, 0, 0},
                   exp_min:-128, exp_min_idx:3, exp_max:127, exp_max_idx:0, exp_count:4};
        vec[4] = '{name:"extremes", len:2, data:'{-128, 127, 0, 0, 0, 0, 0, 0, 0, 0},
                   exp_min:-128, exp_min_idx:0, exp_max:127, exp_max_idx:1, exp_count:2};
        vec[5] = '{name:"ten", len:10, data:'{3, -7, 12, -7, 0, 12, -100, 55, -100, 1},
                   exp_min:-100, exp_min_idx:6, exp_max:55, exp_max_idx:7, exp_count:10};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #12;
        check("reset out_valid", int'(out_valid), 0);
        check("reset in_ready", int'(in_ready), 1);
        check("reset min", int'(out_min), 0);
        check("reset max", int'(out_max), 0);
        check("reset min_idx", int'(out_min_idx), 0);
        check("reset max_idx", int'(out_max_idx), 0);
        check("reset count", int'(out_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < NUM_VEC; v++) begin
            run_burst(vec[v]);
        end

        // Back-pressure: result must hold, and in_ready stay low, while
        // out_ready=0, even with in_valid asserted and junk data.
        send(127, 1'b0);
        send(-128, 1'b0);
        send(127, 1'b0);
        send(-128, 1'b1);
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_data  = 8'sd0;
            in_last  = 1'b1;
            check("hold in_ready", int'(in_ready), 0);
            check("hold out_valid", int'(out_valid), 1);
            check("hold min", int'(out_min), -128);
            check("hold min_idx", int'(out_min_idx), 1);
            check("hold max", int'(out_max), 127);
            check("hold max_idx", int'(out_max_idx), 0);
            check("hold count", int'(out_count), 4);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        expect_result("hold", -128, 1, 127, 0, 4);

        // The ten-element burst again with random idle gaps; junk on in_data
        // while in_valid=0 must be ignored.
        for (int i = 0; i < vec[5].len; i++) begin
            repeat ($urandom_range(0, 3)) begin
                in_data = N'($urandom);
                @(posedge clk);
                #1;
            end
            send(vec[5].data[i], (i == vec[5].len - 1));
        end
        check("gaps latency", int'(out_valid), 1);
        expect_result("gaps", vec[5].exp_min, vec[5].exp_min_idx, vec[5].exp_max,
                      vec[5].exp_max_idx, vec[5].exp_count);

        // Reset mid-burst discards the partial result, asynchronously.
        send(-50, 1'b0);
        send(100, 1'b0);
        send(3, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst count", int'(out_count), 0);
        check("midrst in_ready", int'(in_ready), 1);
        check("midrst out_valid", int'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(2, 1'b0);
        send(1, 1'b1);
        expect_result("after_rst", 1, 1, 2, 0, 2);

        // Count saturation: CW=2 instance saturates at 3, so the late
        // minimum and maximum report the saturated index.
        send(10, 1'b0);
        send(20, 1'b0);
        send(30, 1'b0);
        send(40, 1'b0);
        send(50, 1'b0);
        send(-5, 1'b1);
        check("sat out_valid", int'(s_out_valid), 1);
        check("sat count", int'(s_out_count), 3);
        check("sat min", int'(s_out_min), -5);
        check("sat min_idx", int'(s_out_min_idx), 3);
        check("sat max", int'(s_out_max), 50);
        check("sat max_idx", int'(s_out_max_idx), 3);
        expect_result("wide", -5, 5, 50, 4, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
